// File: rtl/seq_mul.sv
// Sequential shift-add multiplier: one partial product per clock, valid/ready on both sides.
// Two's-complement mode is built only when SEQ_MUL_SIGNED_EN is defined; otherwise signed_mode is ignored.
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | retiring one partial product per edge
// DONE  | Product valid, waiting for out_ready
module seq_mul #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] Product,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_shift;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic             sgn;

  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   partial;
  logic [WIDTH+1:0] hi_ext;
  logic [WIDTH+1:0] part_ext;
  logic [WIDTH+1:0] sum;
  logic [WIDTH:0]   acc_hi_nxt;
  logic [WIDTH-1:0] acc_lo_nxt;
  logic             last;

`ifdef SEQ_MUL_SIGNED_EN
  logic sgn_reg;
  assign sgn = sgn_reg;
`else
  logic unused_signed_mode;
  assign unused_signed_mode = signed_mode;
  assign sgn = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid)       state_nxt = S_RUN;
      S_RUN:  if (count == LAST)  state_nxt = S_DONE;
      S_DONE: if (out_ready)      state_nxt = S_IDLE;
      default:                    state_nxt = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: in_ready = 1'b1;
      S_RUN:  busy     = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // One shift-add step; in signed mode the MSB of B carries negative weight, so it is subtracted.
  always_comb begin
    last       = (count == LAST);
    a_ext      = sgn ? {a_reg[WIDTH-1], a_reg} : {1'b0, a_reg};
    partial    = b_shift[0] ? a_ext : '0;
    hi_ext     = {sgn & acc_hi[WIDTH], acc_hi};
    part_ext   = {sgn & partial[WIDTH], partial};
    sum        = (sgn && last) ? (hi_ext - part_ext) : (hi_ext + part_ext);
    acc_hi_nxt = sum[WIDTH+1:1];
    acc_lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_reg   <= '0;
      b_shift <= '0;
      count   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      Product <= '0;
`ifdef SEQ_MUL_SIGNED_EN
      sgn_reg <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_reg   <= A;
            b_shift <= B;
            count   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
`ifdef SEQ_MUL_SIGNED_EN
            sgn_reg <= signed_mode;
`endif
          end
        end
        S_RUN: begin
          acc_hi  <= acc_hi_nxt;
          acc_lo  <= acc_lo_nxt;
          b_shift <= {1'b0, b_shift[WIDTH-1:1]};
          count   <= count + CW'(1);
          if (last) Product <= {acc_hi_nxt[WIDTH-1:0], acc_lo_nxt};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul.sv
// Directed and randomised self-checking bench for seq_mul at WIDTH=16 and WIDTH=8.
// Signed vectors are exercised only when SEQ_MUL_SIGNED_EN is defined.
module tb_seq_mul;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid16 = 1'b0, in_ready16, sm16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        out_valid16, out_ready16 = 1'b1, busy16;
  logic [31:0] prod16;

  logic        in_valid8 = 1'b0, in_ready8, sm8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        out_valid8, out_ready8 = 1'b1, busy8;
  logic [15:0] prod8;

  seq_mul #(.WIDTH(16)) u_mul16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .A(a16), .B(b16), .signed_mode(sm16), .out_valid(out_valid16),
    .out_ready(out_ready16), .Product(prod16), .busy(busy16)
  );

  seq_mul #(.WIDTH(8)) u_mul8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(a8), .B(b8), .signed_mode(sm8), .out_valid(out_valid8),
    .out_ready(out_ready8), .Product(prod8), .busy(busy8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  // Accept one operation on the 16-bit unit and wait for out_valid; returns at the negedge where it is seen.
  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sm, input logic poke,
                       output logic [31:0] p, output int lat, output int bad_busy);
    int guard;
    guard = 0;
    while (!in_ready16 && guard < 100) begin
      @(posedge clk); @(negedge clk); guard++;
    end
    in_valid16 = 1'b1; a16 = a; b16 = b; sm16 = sm;
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
    lat = 0; bad_busy = 0;
    do begin
      if (poke) begin
        in_valid16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom); sm16 = 1'($urandom);
      end
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (busy16 !== 1'b1 || in_ready16 !== 1'b0) bad_busy++;
    end while (!out_valid16 && lat < 100);
    in_valid16 = 1'b0;
    p = prod16;
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      output logic [15:0] p, output int lat);
    in_valid8 = 1'b1; a8 = a; b8 = b; sm8 = sm;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end while (!out_valid8 && lat < 100);
    p = prod8;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Let the DONE handshake complete (out_ready assumed high) and confirm the return to IDLE.
  task automatic finish16(input string tag);
    out_ready16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check({tag, "_idle_ov"}, 64'(out_valid16), 64'd0);
    check({tag, "_idle_rdy"}, 64'(in_ready16), 64'd1);
    check({tag, "_idle_busy"}, 64'(busy16), 64'd0);
  endtask

  initial begin
    logic [31:0] p;
    logic [15:0] p8;
    logic [15:0] exp8;
    int lat, bad;
    int err_prod, err_lat;

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready16), 64'd1);
    check("rst_out_valid", 64'(out_valid16), 64'd0);
    check("rst_busy", 64'(busy16), 64'd0);
    check("rst_product", 64'(prod16), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run16(16'd3, 16'd5, 1'b0, 1'b0, p, lat, bad);
    check("u3x5_lat", 64'(lat), 64'd16);
    check("u3x5_prod", 64'(p), 64'h0000000F);
    finish16("u3x5");

    run16(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, p, lat, bad);
    check("uffff_lat", 64'(lat), 64'd16);
    check("uffff_prod", 64'(p), 64'hFFFE0001);
    check("uffff_busy", 64'(bad), 64'd0);
    finish16("uffff");

    run16(16'd0, 16'h1234, 1'b0, 1'b0, p, lat, bad);
    check("uzero_lat", 64'(lat), 64'd16);
    check("uzero_prod", 64'(p), 64'h0);
    finish16("uzero");

`ifdef SEQ_MUL_SIGNED_EN
    run16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, p, lat, bad);
    check("s_m1xm1", 64'(p), 64'h00000001);
    finish16("s_m1xm1");
    run16(16'h8000, 16'h8000, 1'b1, 1'b0, p, lat, bad);
    check("s_minxmin", 64'(p), 64'h40000000);
    check("s_minxmin_lat", 64'(lat), 64'd16);
    finish16("s_minxmin");
    run16(16'h0003, 16'hFFFB, 1'b1, 1'b0, p, lat, bad);
    check("s_3xm5", 64'(p), 64'hFFFFFFF1);
    finish16("s_3xm5");
`else
    run16(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, p, lat, bad);
    check("sm_ignored", 64'(p), 64'hFFFE0001);
    finish16("sm_ignored");
`endif

    // Backpressure with in_valid pulsed during RUN and DONE.
    out_ready16 = 1'b0;
    run16(16'h1234, 16'h0056, 1'b0, 1'b1, p, lat, bad);
    check("bp_lat", 64'(lat), 64'd16);
    check("bp_prod", 64'(p), 64'h00061D78);
    check("bp_run_busy", 64'(bad), 64'd0);
    for (int i = 0; i < 5; i++) begin
      in_valid16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom);
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_ov", 64'(out_valid16), 64'd1);
      check("bp_hold_prod", 64'(prod16), 64'h00061D78);
      check("bp_hold_rdy", 64'(in_ready16), 64'd0);
    end
    in_valid16 = 1'b0;
    finish16("bp");
    check("bp_retain", 64'(prod16), 64'h00061D78);

    // Reset while count=7.
    in_valid16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222; sm16 = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_rdy", 64'(in_ready16), 64'd1);
    check("midrst_ov", 64'(out_valid16), 64'd0);
    check("midrst_prod", 64'(prod16), 64'd0);
    check("midrst_busy", 64'(busy16), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run16(16'd7, 16'd9, 1'b0, 1'b0, p, lat, bad);
    check("post_rst_lat", 64'(lat), 64'd16);
    check("post_rst_prod", 64'(p), 64'h0000003F);
    finish16("post_rst");

    // WIDTH=8: directed corners then random pairs against a simple reference.
    run8(8'hFF, 8'hFF, 1'b0, p8, lat);
    check("w8_ffxff", 64'(p8), 64'hFE01);
    check("w8_lat", 64'(lat), 64'd8);
    err_prod = 0; err_lat = 0;
    for (int i = 0; i < 200; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      exp8 = 16'(ra) * 16'(rb);
      run8(ra, rb, 1'b0, p8, lat);
      if (p8 !== exp8) err_prod++;
      if (lat != 8) err_lat++;
    end
    check("w8_rand_prod_errs", 64'(err_prod), 64'd0);
    check("w8_rand_lat_errs", 64'(err_lat), 64'd0);
`ifdef SEQ_MUL_SIGNED_EN
    err_prod = 0;
    for (int i = 0; i < 200; i++) begin
      logic [7:0] ra, rb;
      int sa, sb;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      sa = int'($signed(ra));
      sb = int'($signed(rb));
      exp8 = 16'(sa * sb);
      run8(ra, rb, 1'b1, p8, lat);
      if (p8 !== exp8) err_prod++;
    end
    check("w8_srand_prod_errs", 64'(err_prod), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
